// File: rtl/biriscv_alu_arbiter.sv
// ---------------------------------------------------------------------------
// biriscv_alu_arbiter
//
// Shares one pipelined ALU between the two issue pipes of the dual-issue
// core. At most one request is granted per cycle. When both pipes request
// in the same cycle they are served in round-robin order. The granted
// operation goes straight to the ALU, which registers its own inputs. A
// sideband shift register that matches the ALU latency records who owns
// each in-flight operation and which tag it carries. Each result is then
// steered back to the pipe that issued it.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   reqN_valid_i/ready_o    request handshake for pipe N (N = 0, 1)
//   reqN_op_i/a_i/b_i/tag_i opcode, operands and writeback tag of pipe N
//   flush_i                 squash all in-flight results, block grants
//   alu_valid_o/op_o/a_o/b_o  drive the shared ALU inputs
//   alu_valid_i, alu_p_i    ALU result strobe and value
//   resp0/1_valid_o         result belongs to pipe 0 / pipe 1
//   resp_data_o, resp_tag_o shared result bus and its tag
//   err_o                   sticky: ALU result strobe disagreed with sideband
// ---------------------------------------------------------------------------
module biriscv_alu_arbiter #(
  parameter int TAG_W   = 6,
  parameter int LATENCY = 2   // legal range 1..4
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [3:0]       req0_op_i,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [TAG_W-1:0] req0_tag_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [3:0]       req1_op_i,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [TAG_W-1:0] req1_tag_i,

  input  logic             flush_i,

  output logic             alu_valid_o,
  output logic [3:0]       alu_op_o,
  output logic [31:0]      alu_a_o,
  output logic [31:0]      alu_b_o,
  input  logic             alu_valid_i,
  input  logic [31:0]      alu_p_i,

  output logic             resp0_valid_o,
  output logic             resp1_valid_o,
  output logic [31:0]      resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             err_o
);

  localparam int LAST = LATENCY - 1;

  // Id of the pipe granted most recently. It resets to 1 so that pipe0
  // wins the first tie.
  logic             last_grant_reg;

  logic             grant0;
  logic             grant1;
  logic             grant_any;

  // Sideband stage i describes the operation that has been in the ALU for
  // i+1 cycles. "expect" records whether the ALU should produce a result.
  // "live" records whether that result should still be delivered. The two
  // bits differ only after a flush.
  logic [LATENCY-1:0] live_reg;
  logic [LATENCY-1:0] expect_reg;
  logic [LATENCY-1:0] owner_reg;
  logic [TAG_W-1:0]   tag_reg [LATENCY];

  logic             err_reg;
  logic             resp_live;

  // ------------------------------------------------------------------
  // Grant selection
  // ------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!flush_i) begin
      if (req0_valid_i && req1_valid_i) begin
        // Tie: serve the pipe that did not win last time.
        if (last_grant_reg) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid_i) begin
        grant0 = 1'b1;
      end else if (req1_valid_i) begin
        grant1 = 1'b1;
      end
    end
  end

  assign grant_any    = grant0 | grant1;
  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // With no grant the mux sits on pipe0. Those fields are don't-care
  // because alu_valid_o is low.
  assign alu_valid_o = grant_any;
  assign alu_op_o    = grant1 ? req1_op_i : req0_op_i;
  assign alu_a_o     = grant1 ? req1_a_i  : req0_a_i;
  assign alu_b_o     = grant1 ? req1_b_i  : req0_b_i;

  // ------------------------------------------------------------------
  // Round-robin state, sideband pipeline, sticky error
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_reg <= 1'b1;
      live_reg       <= '0;
      expect_reg     <= '0;
      owner_reg      <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_reg[i] <= '0;
      end
      err_reg        <= 1'b0;
    end else begin
      if (grant_any) begin
        last_grant_reg <= grant1;
      end

      // Grants are already suppressed during a flush, so stage 0 loads a
      // dead entry in that cycle without needing an extra mask.
      live_reg[0]   <= grant_any;
      expect_reg[0] <= grant_any;
      owner_reg[0]  <= grant1;
      tag_reg[0]    <= grant1 ? req1_tag_i : req0_tag_i;

      for (int i = 1; i < LATENCY; i++) begin
        live_reg[i]   <= live_reg[i-1] & ~flush_i;
        expect_reg[i] <= expect_reg[i-1];
        owner_reg[i]  <= owner_reg[i-1];
        tag_reg[i]    <= tag_reg[i-1];
      end

      if (alu_valid_i != expect_reg[LAST]) begin
        err_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Result steering. A flush in the same cycle as a returning result
  // masks that result at once.
  // ------------------------------------------------------------------
  assign resp_live     = live_reg[LAST] & alu_valid_i & ~flush_i;
  assign resp0_valid_o = resp_live & ~owner_reg[LAST];
  assign resp1_valid_o = resp_live &  owner_reg[LAST];
  assign resp_data_o   = alu_p_i;
  assign resp_tag_o    = tag_reg[LAST];
  assign err_o         = err_reg;

endmodule

// File: tb/tb_biriscv_alu_arbiter.sv
// ---------------------------------------------------------------------------
// Directed testbench for biriscv_alu_arbiter. A small two-stage ALU model
// closes the loop between alu_*_o and alu_*_i. Inputs change on the falling
// edge and outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_biriscv_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_XOR = 4'd9;
  localparam logic [3:0] ALU_SLT = 4'd11;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [5:0]  req0_tag, req1_tag;
  logic        flush;
  logic        alu_valid_o, alu_valid_i;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_p;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic [5:0]  resp_tag;
  logic        err;
  logic        force_v;

  int n_cmp  = 0;
  int n_fail = 0;

  biriscv_alu_arbiter #(.TAG_W(6), .LATENCY(2)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_op_i    (req0_op),
    .req0_a_i     (req0_a),
    .req0_b_i     (req0_b),
    .req0_tag_i   (req0_tag),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_op_i    (req1_op),
    .req1_a_i     (req1_a),
    .req1_b_i     (req1_b),
    .req1_tag_i   (req1_tag),
    .flush_i      (flush),
    .alu_valid_o  (alu_valid_o),
    .alu_op_o     (alu_op),
    .alu_a_o      (alu_a),
    .alu_b_o      (alu_b),
    .alu_valid_i  (alu_valid_i),
    .alu_p_i      (alu_p),
    .resp0_valid_o(resp0_valid),
    .resp1_valid_o(resp1_valid),
    .resp_data_o  (resp_data),
    .resp_tag_o   (resp_tag),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage ALU model, reset together with the arbiter
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      ALU_ADD: alu_f = a + b;
      ALU_SUB: alu_f = a - b;
      ALU_XOR: alu_f = a ^ b;
      ALU_SLT: alu_f = {31'd0, ($signed(a) < $signed(b))};
      default: alu_f = 32'd0;
    endcase
  endfunction

  logic        s1_v, s2_v;
  logic [31:0] s1_p, s2_p;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_p <= '0;
      s2_p <= '0;
    end else begin
      s1_v <= alu_valid_o;
      s1_p <= alu_f(alu_op, alu_a, alu_b);
      s2_v <= s1_v;
      s2_p <= s1_p;
    end
  end
  assign alu_valid_i = s2_v | force_v;
  assign alu_p       = s2_p;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    $display("t=%0t %s observed=%0h expected=%0h", $time, name, obs, exp);
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_op = ALU_ADD; req0_a = '0; req0_b = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_op = ALU_ADD; req1_a = '0; req1_b = '0; req1_tag = '0;
    flush = 1'b0;
    force_v = 1'b0;
  endtask

  task automatic drv0(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] t);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_tag = t;
  endtask

  task automatic drv1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [5:0] t);
    req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_tag = t;
  endtask

  // Advance to the next cycle with idle inputs and reset released.
  task automatic step();
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  // Hold reset across two rising edges and check the reset state.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    #1;
    chk("rst_err",   32'(err),         32'd0);
    chk("rst_resp0", 32'(resp0_valid), 32'd0);
    chk("rst_resp1", 32'(resp1_valid), 32'd0);
    chk("rst_alu_v", 32'(alu_valid_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle();

    // ---------------- 1: single ADD on pipe0 ----------------
    do_reset();
    step(); drv0(ALU_ADD, 32'd5, 32'd7, 6'd3); #1;
    chk("t1_ready0", 32'(req0_ready), 32'd1);
    chk("t1_ready1", 32'(req1_ready), 32'd0);
    chk("t1_alu_v",  32'(alu_valid_o), 32'd1);
    chk("t1_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("t1_alu_a",  alu_a, 32'd5);
    step(); #1;
    chk("t1_early",  32'(resp0_valid), 32'd0);
    chk("t1_idle_alu_v", 32'(alu_valid_o), 32'd0);
    step(); #1;
    chk("t1_resp0",  32'(resp0_valid), 32'd1);
    chk("t1_resp1",  32'(resp1_valid), 32'd0);
    chk("t1_data",   resp_data, 32'd12);
    chk("t1_tag",    32'(resp_tag), 32'd3);
    step(); #1;
    chk("t1_after",  32'(resp0_valid), 32'd0);

    // ---------------- 2: continuous tie, alternating grants ----------------
    // Pipe p, op index i: a = 100*p + i, b = 1, tag = 8 + 16*p + i.
    // A pipe holds its request until it is accepted.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      step();
      if (k < 6) begin
        drv0(ALU_ADD, 32'((k + 1) / 2), 32'd1, 6'(8 + (k + 1) / 2));
        drv1(ALU_ADD, 32'(100 + k / 2), 32'd1, 6'(24 + k / 2));
      end
      #1;
      if (k < 6) begin
        chk($sformatf("t2_ready0_c%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
        chk($sformatf("t2_ready1_c%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
      end
      if (k >= 2) begin
        chk($sformatf("t2_resp0_c%0d", k), 32'(resp0_valid), 32'((k - 2) % 2 == 0));
        chk($sformatf("t2_resp1_c%0d", k), 32'(resp1_valid), 32'((k - 2) % 2 == 1));
        chk($sformatf("t2_data_c%0d", k), resp_data,
            32'(((k - 2) % 2) * 100 + (k - 2) / 2 + 1));
        chk($sformatf("t2_tag_c%0d", k), 32'(resp_tag),
            32'(8 + ((k - 2) % 2) * 16 + (k - 2) / 2));
      end
    end
    step(); #1;
    chk("t2_drain0", 32'(resp0_valid), 32'd0);
    chk("t2_drain1", 32'(resp1_valid), 32'd0);

    // ---------------- 3: back-to-back on pipe1 ----------------
    step(); drv1(ALU_SUB, 32'd10, 32'd3, 6'd5); #1;
    chk("t3_ready1_a", 32'(req1_ready), 32'd1);
    chk("t3_alu_op",   32'(alu_op), 32'(ALU_SUB));
    step(); drv1(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 6'd6); #1;
    chk("t3_ready1_b", 32'(req1_ready), 32'd1);
    step(); #1;
    chk("t3_resp1_a", 32'(resp1_valid), 32'd1);
    chk("t3_resp0_a", 32'(resp0_valid), 32'd0);
    chk("t3_data_a",  resp_data, 32'd7);
    chk("t3_tag_a",   32'(resp_tag), 32'd5);
    step(); #1;
    chk("t3_resp1_b", 32'(resp1_valid), 32'd1);
    chk("t3_data_b",  resp_data, 32'd1);
    chk("t3_tag_b",   32'(resp_tag), 32'd6);
    step(); #1;
    chk("t3_after",   32'(resp1_valid), 32'd0);

    // ---------------- 4: flush squashes in-flight ops ----------------
    step(); drv0(ALU_ADD, 32'd1, 32'd1, 6'd1); #1;
    chk("t4_ready_a", 32'(req0_ready), 32'd1);
    step(); drv0(ALU_ADD, 32'd2, 32'd2, 6'd2); #1;
    chk("t4_ready_b", 32'(req0_ready), 32'd1);
    step(); flush = 1'b1; drv0(ALU_ADD, 32'd3, 32'd3, 6'd9); #1;
    chk("t4_fl_ready", 32'(req0_ready), 32'd0);
    chk("t4_fl_alu_v", 32'(alu_valid_o), 32'd0);
    chk("t4_fl_resp0", 32'(resp0_valid), 32'd0);
    step(); drv0(ALU_ADD, 32'd4, 32'd4, 6'd10); #1;
    chk("t4_post_ready", 32'(req0_ready), 32'd1);
    chk("t4_sq_resp0",   32'(resp0_valid), 32'd0);
    chk("t4_err_a",      32'(err), 32'd0);
    step(); #1;
    chk("t4_gap_resp0",  32'(resp0_valid), 32'd0);
    chk("t4_err_b",      32'(err), 32'd0);
    step(); #1;
    chk("t4_new_resp0",  32'(resp0_valid), 32'd1);
    chk("t4_new_data",   resp_data, 32'd8);
    chk("t4_new_tag",    32'(resp_tag), 32'd10);
    step(); #1;
    chk("t4_err_c",      32'(err), 32'd0);

    // ---------------- 5: spurious ALU valid -> sticky error ----------------
    step(); force_v = 1'b1; #1;
    chk("t5_err_same", 32'(err), 32'd0);
    chk("t5_no_resp",  32'(resp0_valid | resp1_valid), 32'd0);
    step(); #1;
    chk("t5_err_set",  32'(err), 32'd1);
    step(); step(); #1;
    chk("t5_err_hold", 32'(err), 32'd1);

    // ---------------- 6: reset with ops in flight ----------------
    // Pipe0 was granted last, so a tie without reset would go to pipe1.
    step(); drv0(ALU_ADD, 32'd20, 32'd1, 6'd11); #1;
    chk("t6_ready_a", 32'(req0_ready), 32'd1);
    step(); drv0(ALU_ADD, 32'd21, 32'd1, 6'd12); #1;
    chk("t6_ready_b", 32'(req0_ready), 32'd1);
    do_reset();
    step();
    drv0(ALU_ADD, 32'd30, 32'd1, 6'd13);
    drv1(ALU_ADD, 32'd40, 32'd1, 6'd14);
    #1;
    chk("t6_tie_ready0", 32'(req0_ready), 32'd1);
    chk("t6_tie_ready1", 32'(req1_ready), 32'd0);
    chk("t6_resp_a",     32'(resp0_valid | resp1_valid), 32'd0);
    step();
    drv0(ALU_ADD, 32'd31, 32'd1, 6'd15);
    drv1(ALU_ADD, 32'd40, 32'd1, 6'd14);
    #1;
    chk("t6_tie2_ready0", 32'(req0_ready), 32'd0);
    chk("t6_tie2_ready1", 32'(req1_ready), 32'd1);
    chk("t6_resp_b",      32'(resp0_valid | resp1_valid), 32'd0);
    step(); #1;
    chk("t6_r0_valid", 32'(resp0_valid), 32'd1);
    chk("t6_r0_data",  resp_data, 32'd31);
    chk("t6_r0_tag",   32'(resp_tag), 32'd13);
    step(); #1;
    chk("t6_r1_valid", 32'(resp1_valid), 32'd1);
    chk("t6_r1_data",  resp_data, 32'd41);
    chk("t6_r1_tag",   32'(resp_tag), 32'd14);
    step(); #1;
    chk("t6_err", 32'(err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/biriscv_alu_arbiter.md
Name: biriscv_alu_arbiter

Overview:
Shares one 2-stage pipelined ALU between the two issue pipes (pipe0/pipe1) of the dual-issue core. Each pipe uses a valid/ready request handshake. The block grants at most one request per cycle using round-robin priority. It drives the ALU inputs, tracks the requester and tag of each in-flight operation in a sideband pipeline matched to ALU latency, and steers each result back to its owner. It also supports a pipeline flush that squashes in-flight results.

Parameters:
TAG_W, 6, width of requester tag (ROB/writeback tag) carried alongside each op.
LATENCY, 2, ALU cycles from accepted input to valid output; legal range 1..4; sideband pipe depth.

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous active-high reset
req0_valid_i  input  1  pipe0 has an ALU op
req0_ready_o  output  1  pipe0 op accepted this cycle
req0_op_i  input  4  pipe0 ALU opcode (ALU_* encoding)
req0_a_i  input  32  pipe0 operand A
req0_b_i  input  32  pipe0 operand B
req0_tag_i  input  TAG_W  pipe0 tag
req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i, req1_tag_i: same as pipe0, for pipe1
flush_i  input  1  squash all in-flight ops; block grants this cycle
alu_valid_o  output  1  to ALU valid_i
alu_op_o  output  4  to ALU alu_op_i
alu_a_o  output  32  to ALU alu_a_i
alu_b_o  output  32  to ALU alu_b_i
alu_valid_i  input  1  from ALU valid_o
alu_p_i  input  32  from ALU alu_p_o
resp0_valid_o  output  1  result for pipe0
resp1_valid_o  output  1  result for pipe1
resp_data_o  output  32  result value (shared bus)
resp_tag_o  output  TAG_W  tag of returned result
err_o  output  1  sticky: alu_valid_i disagrees with expected sideband

Behaviour:
- All state resets synchronously on rst_i. After reset: sideband pipe empty, last_grant=1 (pipe0 wins first tie), err_o=0, all valid/ready outputs 0.
- Grant logic is combinational within the cycle:
  - If flush_i=1: no grant. Both ready=0, alu_valid_o=0.
  - Else if only one req valid: grant it.
  - If both are valid: grant the pipe != last_grant. last_grant updates on every grant.
  - reqX_ready_o=1 only for the granted pipe. Handshake = valid & ready.
- alu_valid_o = any grant. alu_op/a/b_o mux the granted pipe's fields. When there is no grant they carry pipe0 fields (don't-care). No input registering here; the ALU registers its inputs.
- Sideband pipe: LATENCY-deep shift register of {live, expect, owner, tag}, advancing every cycle with no stall.
  - Stage 0 loads expect=live=grant, owner=granted id, tag.
  - flush_i clears live in all stages, including the stage loaded this cycle (which loads nothing, since there is no grant). expect is unaffected.
- Result at stage LATENCY-1 output (op accepted in cycle N returns in cycle N+LATENCY):
  - resp0_valid_o = live & owner==0 & alu_valid_i; resp1_valid_o likewise for owner==1. At most one is high.
  - resp_data_o=alu_p_i and resp_tag_o=sideband tag, combinational.
  - No backpressure on responses; owners must always sink.
- err_o sets when alu_valid_i != expect at the final stage. It stays set until reset.
- Throughput: one op per cycle sustained. Back-to-back grants to the same pipe are allowed when the other pipe is idle.
- Reset mid-operation: in-flight entries are discarded; the ALU is also reset, so no spurious responses and no err_o.
- Flush in the same cycle as a result return: the result is suppressed (live cleared before it is used; flush masks resp*_valid_o combinationally in that cycle).

Test Plan:
1. Reset, then req0 only (op=ADD, a=5, b=7, tag=3) in cycle 1 -> req0_ready_o=1 in cycle 1; cycle 3: resp0_valid_o=1, resp_data_o=12, resp_tag_o=3, resp1_valid_o=0.
2. Both pipes valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1. Responses return in the same order 2 cycles later with correct tags and no gaps.
3. Back-to-back ops: pipe1 SUB 10-3, then SLT_SIGNED -1<1 -> responses 7 then 1 on consecutive cycles, owner=1.
4. Issue 2 ops, assert flush_i the cycle after the second -> no resp*_valid_o for either; err_o stays 0; new requests are accepted the cycle after the flush.
5. Force alu_valid_i=1 with the sideband empty -> err_o=1 the next cycle and remains set until rst_i.
6. Assert rst_i with 2 ops in flight, deassert -> no responses, req0 wins the first subsequent tie.
